acc_data_router: RTL and testbench
==================================

Name: acc_data_router

Overview:
- Data-movement stage directly downstream of the PLA controller (`pla_top`). It consumes the PLA's one-hot `fft_enable`/`fir_enable`/`iir_enable` and produces the `*_read_done`/`*_write_done` handshakes the PLA waits on.
- For the selected accelerator it streams a fixed-length input block from shared memory into that accelerator, then writes the accelerator's result words back to memory.

Parameters:
- DATA_W, 32, memory/accelerator data width.
- ADDR_W, 10, memory address width.
- RD_BASE, 0, first memory address read for any job.
- WR_BASE, 512, first memory address written for any job.
- FFT_LEN, 16, words read and words written for an FFT job (>=1).
- FIR_LEN, 8, words read/written for a FIR job (>=1).
- IIR_LEN, 8, words read/written for an IIR job (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fft_enable  in  1  job request from the PLA, level.
- fir_enable  in  1  job request from the PLA, level.
- iir_enable  in  1  job request from the PLA, level.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  memory read strobe; data is returned 1 cycle later.
- mem_rdata  in  DATA_W  memory read data.
- mem_wr_en  out  1  memory write strobe.
- mem_wdata  out  DATA_W  memory write data.
- acc_sel  out  2  active accelerator: 0 none, 1 FFT, 2 FIR, 3 IIR.
- acc_in_data  out  DATA_W  word presented to the accelerator.
- acc_in_valid  out  1  acc_in_data is valid this cycle.
- acc_out_data  in  DATA_W  result word from the accelerator.
- acc_out_valid  in  1  acc_out_data is valid this cycle.
- fft_read_done, fft_write_done  out  1 each  level handshakes to the PLA.
- fir_read_done, fir_write_done  out  1 each  level handshakes to the PLA.
- iir_read_done, iir_write_done  out  1 each  level handshakes to the PLA.

Behaviour:
- Reset:
  - All outputs are 0; state is IDLE; counters are 0.
  - Reset overrides everything, including a job in progress.
- State machine states: IDLE, READ, DRAIN, WRITE, DONE. All outputs are registered.
- IDLE:
  - On any enable high: latch the job with priority FFT > FIR > IIR, set acc_sel, set LEN, and go to READ.
  - Lower-priority enables that are high at the same time are ignored.
- READ (issues LEN reads):
  - Each cycle: mem_rd_en=1 and mem_addr=RD_BASE+rcnt; rcnt increments.
  - When rcnt reaches LEN-1, go to DRAIN.
  - acc_in_valid=1 and acc_in_data=mem_rdata in the cycle after each read. This delivers exactly LEN beats, with no gaps.
- DRAIN: one cycle. The last word is delivered; mem_rd_en=0. Then set the selected read_done and go to WRITE.
- WRITE:
  - Each cycle with acc_out_valid=1 produces, on the next cycle: mem_wr_en=1, mem_addr=WR_BASE+wcnt, mem_wdata=captured word; wcnt increments.
  - After LEN writes have issued, set the selected write_done and go to DONE.
- DONE: read_done and write_done are held high until the selected enable goes low; then all done flags clear, acc_sel=0, and the state returns to IDLE.
- Level handshake: read_done, once set, stays high through WRITE and DONE.
- acc_out_valid outside WRITE is ignored; no memory write occurs.
- Abort: if the latched enable drops during READ, DRAIN or WRITE:
  - Return to IDLE on the next cycle.
  - All strobes and done flags clear.
  - Memory writes already issued are not undone.
- Counters are ceil(log2(max LEN))+1 bits wide. Address arithmetic wraps modulo 2^ADDR_W.
- Latency from enable high (IDLE) to first mem_rd_en is 1 cycle. Latency to read_done is LEN+2 cycles.

Optional Feature:
- Macro: ROUTER_ERR_EN.
- When defined, the block adds output `err` (1 bit, reset 0). `err` is sticky until reset and sets when either:
  - more than one enable is high while in IDLE, or
  - acc_out_valid=1 in any state other than WRITE.
- When undefined, there is no `err` port and these conditions are silently ignored as described in Behaviour.

Test Plan:
- FFT job (FFT_LEN=16), memory preloaded with addr i = i:
  - 16 consecutive acc_in_valid beats carrying data 0..15.
  - fft_read_done rises at cycle 18 after the enable.
  - 16 acc_out_valid beats of value 0xA0+i land at addresses 512..527.
  - fft_write_done then rises; both done flags clear 1 cycle after fft_enable drops.
- FIR, then IIR, back-to-back, each LEN=8, sequenced like the PLA bench: acc_sel=2 then 3; only the matching *_done flags toggle; the other accelerators' done outputs stay 0.
- fft_enable and iir_enable raised in the same cycle: FFT job runs; no iir_* activity. With ROUTER_ERR_EN, err=1.
- fir_enable dropped after 3 reads: state returns to IDLE next cycle; mem_rd_en=0; fir_read_done never asserts; a subsequent FIR job starts again at address 0.
- acc_out_valid pulsed during READ: no mem_wr_en. With ROUTER_ERR_EN, err=1, and it stays 1 until reset.
- reset asserted mid-WRITE: all outputs are 0 on the next cycle; a new enable restarts the job from RD_BASE.

Source files
------------

// File: rtl/acc_data_router_if.sv
// acc_data_router_if: PLA enable/done handshakes, shared-memory port and accelerator stream
// of acc_data_router. The router connects through modport master.
interface acc_data_router_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              fft_enable;
    logic              fir_enable;
    logic              iir_enable;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        acc_sel;
    logic [DATA_W-1:0] acc_in_data;
    logic              acc_in_valid;
    logic [DATA_W-1:0] acc_out_data;
    logic              acc_out_valid;
    logic              fft_read_done;
    logic              fft_write_done;
    logic              fir_read_done;
    logic              fir_write_done;
    logic              iir_read_done;
    logic              iir_write_done;

    modport master (
        input  fft_enable, fir_enable, iir_enable, mem_rdata, acc_out_data, acc_out_valid,
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, acc_sel, acc_in_data, acc_in_valid,
               fft_read_done, fft_write_done, fir_read_done, fir_write_done,
               iir_read_done, iir_write_done
    );

    modport slave (
        output fft_enable, fir_enable, iir_enable, mem_rdata, acc_out_data, acc_out_valid,
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, acc_sel, acc_in_data, acc_in_valid,
               fft_read_done, fft_write_done, fir_read_done, fir_write_done,
               iir_read_done, iir_write_done
    );
endinterface

// File: rtl/acc_data_router.sv
// acc_data_router: streams a job's input block from shared memory into the selected accelerator,
// then writes its results back. Define ROUTER_ERR_EN to add the sticky protocol-error output err.
module acc_data_router #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int RD_BASE = 0,
    parameter int WR_BASE = 512,
    parameter int FFT_LEN = 16,
    parameter int FIR_LEN = 8,
    parameter int IIR_LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    acc_data_router_if.master bus
`ifdef ROUTER_ERR_EN
    ,
    output logic              err
`endif
);
    localparam int MAX_LEN = (FFT_LEN > FIR_LEN) ? ((FFT_LEN > IIR_LEN) ? FFT_LEN : IIR_LEN)
                                                 : ((FIR_LEN > IIR_LEN) ? FIR_LEN : IIR_LEN);
    localparam int CNT_W = $clog2(MAX_LEN) + 1;
    localparam logic [ADDR_W-1:0] RD_BASE_A = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0] WR_BASE_A = ADDR_W'(WR_BASE);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE} state_t;

    state_t            r_state, w_state_nxt;
    logic [1:0]        r_sel, w_sel_nxt;
    logic [CNT_W-1:0]  r_len, w_len_nxt;
    logic [CNT_W-1:0]  r_rcnt, w_rcnt_nxt;
    logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_rd_en, w_rd_en_nxt;
    logic              r_rd_pend, w_rd_pend_nxt;
    logic              r_wr_en, w_wr_en_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_in_valid, w_in_valid_nxt;
    logic [DATA_W-1:0] r_in_data, w_in_data_nxt;
    logic [2:0]        r_rd_done, w_rd_done_nxt;
    logic [2:0]        r_wr_done, w_wr_done_nxt;
    logic              w_any;
    logic              w_sel_en;
    logic [2:0]        w_job_mask;

    assign w_any      = bus.fft_enable | bus.fir_enable | bus.iir_enable;
    assign w_job_mask = {r_sel == 2'd3, r_sel == 2'd2, r_sel == 2'd1};
    assign w_sel_en   = |(w_job_mask & {bus.iir_enable, bus.fir_enable, bus.fft_enable});

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Any drop of the latched enable outside IDLE/DONE is an abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_READ;
            S_READ:  if (!w_sel_en) w_state_nxt = S_IDLE;
                     else if (r_rcnt == r_len - CNT_W'(1)) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = w_sel_en ? S_WRITE : S_IDLE;
            S_WRITE: if (!w_sel_en) w_state_nxt = S_IDLE;
                     else if (r_wcnt == r_len) w_state_nxt = S_DONE;
            S_DONE:  if (!w_sel_en) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sel_nxt      = r_sel;
        w_len_nxt      = r_len;
        w_rcnt_nxt     = r_rcnt;
        w_wcnt_nxt     = r_wcnt;
        w_addr_nxt     = r_addr;
        w_rd_en_nxt    = 1'b0;
        w_rd_pend_nxt  = r_rd_en;
        w_wr_en_nxt    = 1'b0;
        w_wdata_nxt    = r_wdata;
        w_in_valid_nxt = r_rd_pend;
        w_in_data_nxt  = r_rd_pend ? bus.mem_rdata : r_in_data;
        w_rd_done_nxt  = r_rd_done;
        w_wr_done_nxt  = r_wr_done;
        case (r_state)
            S_IDLE: if (w_any) begin
                if (bus.fft_enable) begin
                    w_sel_nxt = 2'd1;
                    w_len_nxt = CNT_W'(FFT_LEN);
                end else if (bus.fir_enable) begin
                    w_sel_nxt = 2'd2;
                    w_len_nxt = CNT_W'(FIR_LEN);
                end else begin
                    w_sel_nxt = 2'd3;
                    w_len_nxt = CNT_W'(IIR_LEN);
                end
                w_rcnt_nxt  = '0;
                w_wcnt_nxt  = '0;
                w_addr_nxt  = RD_BASE_A;
                w_rd_en_nxt = 1'b1;
            end
            S_READ: if (w_state_nxt == S_READ) begin
                w_rcnt_nxt  = r_rcnt + CNT_W'(1);
                w_addr_nxt  = RD_BASE_A + ADDR_W'(w_rcnt_nxt);
                w_rd_en_nxt = 1'b1;
            end
            S_DRAIN: if (w_state_nxt == S_WRITE) w_rd_done_nxt = r_rd_done | w_job_mask;
            S_WRITE: begin
                if (w_state_nxt == S_DONE) begin
                    w_wr_done_nxt = r_wr_done | w_job_mask;
                end else if (w_state_nxt == S_WRITE && bus.acc_out_valid) begin
                    w_wr_en_nxt = 1'b1;
                    w_addr_nxt  = WR_BASE_A + ADDR_W'(r_wcnt);
                    w_wdata_nxt = bus.acc_out_data;
                    w_wcnt_nxt  = r_wcnt + CNT_W'(1);
                end
            end
            default: ;
        endcase
        // Returning to IDLE (job finished or aborted) drops every strobe and handshake,
        // including the beat of a read still in flight.
        if (w_state_nxt == S_IDLE) begin
            w_sel_nxt      = 2'd0;
            w_rd_en_nxt    = 1'b0;
            w_rd_pend_nxt  = 1'b0;
            w_wr_en_nxt    = 1'b0;
            w_in_valid_nxt = 1'b0;
            w_rd_done_nxt  = '0;
            w_wr_done_nxt  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel      <= '0;
            r_len      <= '0;
            r_rcnt     <= '0;
            r_wcnt     <= '0;
            r_addr     <= '0;
            r_rd_en    <= 1'b0;
            r_rd_pend  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
            r_in_valid <= 1'b0;
            r_in_data  <= '0;
            r_rd_done  <= '0;
            r_wr_done  <= '0;
        end else begin
            r_sel      <= w_sel_nxt;
            r_len      <= w_len_nxt;
            r_rcnt     <= w_rcnt_nxt;
            r_wcnt     <= w_wcnt_nxt;
            r_addr     <= w_addr_nxt;
            r_rd_en    <= w_rd_en_nxt;
            r_rd_pend  <= w_rd_pend_nxt;
            r_wr_en    <= w_wr_en_nxt;
            r_wdata    <= w_wdata_nxt;
            r_in_valid <= w_in_valid_nxt;
            r_in_data  <= w_in_data_nxt;
            r_rd_done  <= w_rd_done_nxt;
            r_wr_done  <= w_wr_done_nxt;
        end
    end

    assign bus.mem_addr       = r_addr;
    assign bus.mem_rd_en      = r_rd_en;
    assign bus.mem_wr_en      = r_wr_en;
    assign bus.mem_wdata      = r_wdata;
    assign bus.acc_sel        = r_sel;
    assign bus.acc_in_data    = r_in_data;
    assign bus.acc_in_valid   = r_in_valid;
    assign bus.fft_read_done  = r_rd_done[0];
    assign bus.fir_read_done  = r_rd_done[1];
    assign bus.iir_read_done  = r_rd_done[2];
    assign bus.fft_write_done = r_wr_done[0];
    assign bus.fir_write_done = r_wr_done[1];
    assign bus.iir_write_done = r_wr_done[2];

`ifdef ROUTER_ERR_EN
    logic r_err;
    logic w_err_hit;

    assign w_err_hit = (r_state == S_IDLE &&
                        ((bus.fft_enable & bus.fir_enable) | (bus.fft_enable & bus.iir_enable) |
                         (bus.fir_enable & bus.iir_enable))) ||
                       (bus.acc_out_valid && r_state != S_WRITE);

    always_ff @(posedge clk) begin
        if (reset)          r_err <= 1'b0;
        else if (w_err_hit) r_err <= 1'b1;
    end

    assign err = r_err;
`endif
endmodule

// File: tb/tb_acc_data_router.sv
// Directed bench for acc_data_router: FFT/FIR/IIR jobs, priority, abort, stray results and reset.
// Memory model returns its own address as data; results are checked on the write strobe.
`timescale 1ns/1ps
module tb_acc_data_router;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    acc_data_router_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
`ifdef ROUTER_ERR_EN
    logic err;
`endif

    acc_data_router #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_BASE(0), .WR_BASE(512),
        .FFT_LEN(16), .FIR_LEN(8), .IIR_LEN(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ROUTER_ERR_EN
        ,
        .err   (err)
`endif
    );

    always #5 clk = ~clk;

    // Preloaded memory: word at address i holds i, read latency one cycle.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= DATA_W'(bus.mem_addr);
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] done_vec();
        return {bus.fft_read_done, bus.fft_write_done, bus.fir_read_done,
                bus.fir_write_done, bus.iir_read_done, bus.iir_write_done};
    endfunction

    task automatic set_en(input int sel, input logic v);
        case (sel)
            1:       bus.fft_enable = v;
            2:       bus.fir_enable = v;
            default: bus.iir_enable = v;
        endcase
    endtask

    task automatic clear_all_en();
        bus.fft_enable = 1'b0;
        bus.fir_enable = 1'b0;
        bus.iir_enable = 1'b0;
    endtask

    // Full job: LEN reads + DRAIN, LEN results written to 512.., then the enable is released.
    task automatic run_job(input int sel, input int len, input logic [31:0] obase);
        logic [5:0] rdm;
        logic [5:0] wrm;
        rdm = 6'b100000 >> (2 * (sel - 1));
        wrm = 6'b010000 >> (2 * (sel - 1));
        set_en(sel, 1'b1);
        for (int k = 1; k <= len + 2; k++) begin
            tick();
            chk("acc_sel_read", bus.acc_sel, sel);
            chk("rd_en", bus.mem_rd_en, (k <= len));
            if (k <= len) chk("rd_addr", bus.mem_addr, k - 1);
            chk("wr_en_read", bus.mem_wr_en, 1'b0);
            chk("in_valid", bus.acc_in_valid, (k >= 3));
            if (k >= 3) chk("in_data", bus.acc_in_data, k - 3);
            chk("done_read", done_vec(), (k == len + 2) ? rdm : 6'b0);
        end
        tick();
        chk("in_valid_after", bus.acc_in_valid, 1'b0);
        chk("done_write_start", done_vec(), rdm);
        for (int i = 0; i < len; i++) begin
            bus.acc_out_valid = 1'b1;
            bus.acc_out_data  = obase + 32'(i);
            tick();
            chk("wr_en", bus.mem_wr_en, 1'b1);
            chk("wr_addr", bus.mem_addr, 512 + i);
            chk("wr_data", bus.mem_wdata, obase + 32'(i));
            chk("done_writing", done_vec(), rdm);
            chk("acc_sel_write", bus.acc_sel, sel);
        end
        bus.acc_out_valid = 1'b0;
        tick();
        chk("wr_en_end", bus.mem_wr_en, 1'b0);
        chk("done_both", done_vec(), rdm | wrm);
        tick();
        chk("done_hold", done_vec(), rdm | wrm);
        clear_all_en();
        tick();
        chk("done_clear", done_vec(), 6'b0);
        chk("acc_sel_clear", bus.acc_sel, 2'd0);
    endtask

    initial begin
        reset             = 1'b1;
        bus.fft_enable    = 1'b0;
        bus.fir_enable    = 1'b0;
        bus.iir_enable    = 1'b0;
        bus.acc_out_valid = 1'b0;
        bus.acc_out_data  = '0;
        tick();
        tick();
        chk("rst_rd_en", bus.mem_rd_en, 1'b0);
        chk("rst_wr_en", bus.mem_wr_en, 1'b0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_sel", bus.acc_sel, 2'd0);
        chk("rst_in_valid", bus.acc_in_valid, 1'b0);
        chk("rst_done", done_vec(), 6'b0);
`ifdef ROUTER_ERR_EN
        chk("rst_err", err, 1'b0);
`endif
        reset = 1'b0;
        tick();

        run_job(1, 16, 32'hA0);
        run_job(2, 8, 32'h100);
        run_job(3, 8, 32'h200);
`ifdef ROUTER_ERR_EN
        chk("err_clean_jobs", err, 1'b0);
`endif

        // FFT and IIR requested together: FFT wins, no iir_* activity (checked via done_vec).
        bus.iir_enable = 1'b1;
        run_job(1, 16, 32'hC0);
`ifdef ROUTER_ERR_EN
        chk("err_multi_en", err, 1'b1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
`ifdef ROUTER_ERR_EN
        chk("err_cleared", err, 1'b0);
`endif

        // Abort a FIR job after 3 reads.
        bus.fir_enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("abort_rd_addr", bus.mem_addr, k - 1);
        end
        bus.fir_enable = 1'b0;
        tick();
        chk("abort_rd_en", bus.mem_rd_en, 1'b0);
        chk("abort_in_valid", bus.acc_in_valid, 1'b0);
        chk("abort_sel", bus.acc_sel, 2'd0);
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("abort_no_done", done_vec(), 6'b0);
            chk("abort_idle_rd", bus.mem_rd_en, 1'b0);
        end
        run_job(2, 8, 32'h300);

        // Stray accelerator result during READ must not reach memory.
        bus.fir_enable = 1'b1;
        tick();
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = 32'h55;
        tick();
        chk("stray_wr_en0", bus.mem_wr_en, 1'b0);
        bus.acc_out_valid = 1'b0;
        tick();
        chk("stray_wr_en1", bus.mem_wr_en, 1'b0);
        bus.fir_enable = 1'b0;
        tick();
        chk("stray_idle_sel", bus.acc_sel, 2'd0);
        tick();
        tick();
`ifdef ROUTER_ERR_EN
        chk("err_stray_sticky", err, 1'b1);
`endif

        // Reset in the middle of WRITE.
        bus.fir_enable = 1'b1;
        for (int k = 0; k < 11; k++) tick();
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = 32'h77;
        tick();
        chk("midw_addr0", bus.mem_addr, 512);
        tick();
        chk("midw_addr1", bus.mem_addr, 513);
        chk("midw_wr_en", bus.mem_wr_en, 1'b1);
        reset          = 1'b1;
        bus.fir_enable = 1'b0;
        tick();
        chk("midrst_wr_en", bus.mem_wr_en, 1'b0);
        chk("midrst_rd_en", bus.mem_rd_en, 1'b0);
        chk("midrst_addr", bus.mem_addr, 0);
        chk("midrst_wdata", bus.mem_wdata, 0);
        chk("midrst_sel", bus.acc_sel, 2'd0);
        chk("midrst_in_valid", bus.acc_in_valid, 1'b0);
        chk("midrst_in_data", bus.acc_in_data, 0);
        chk("midrst_done", done_vec(), 6'b0);
`ifdef ROUTER_ERR_EN
        chk("midrst_err", err, 1'b0);
`endif
        reset             = 1'b0;
        bus.acc_out_valid = 1'b0;
        tick();
        chk("postrst_idle", bus.mem_rd_en, 1'b0);
        run_job(2, 8, 32'h400);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
